// File: rtl/adcdac_2g_spi_master.sv
// SPI mode-0 master driving the ADC/DAC LVDS buffer stage; IDLE/SETUP/SHIFT/HOLD sequencer.
// Optional readback of user_spi_dout (2-flop synchronizer + capture register) via ADCDAC_SPI_READBACK_EN.
module adcdac_2g_spi_master #(
  parameter int WORD_BITS = 24,
  parameter int CLK_DIV   = 4,
  parameter int CS_SETUP  = 2,
  parameter int CS_HOLD   = 2
) (
  input  logic                 fpga_clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WORD_BITS-1:0] wdata,
  output logic                 busy,
  output logic                 done,
  output logic [WORD_BITS-1:0] rdata,
  output logic                 user_spi_clk,
  output logic                 user_spi_ss,
  output logic                 user_spi_din,
  input  logic                 user_spi_dout
);
  localparam int CNT_M1  = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int CNT_MAX = (CNT_M1 > CS_HOLD) ? CNT_M1 : CS_HOLD;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int BW      = $clog2(WORD_BITS);

  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_SETUP = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_HOLD  = CW'(CS_HOLD - 1);
  localparam logic [BW-1:0] BIT_ZERO  = {BW{1'b0}};
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WORD_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_cnt;
  logic [WORD_BITS-1:0] shreg;

  // Transaction sequencer; every protocol output is a register written here
  always_ff @(posedge fpga_clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= CNT_ZERO;
      bit_cnt      <= BIT_ZERO;
      shreg        <= {WORD_BITS{1'b0}};
      busy         <= 1'b0;
      done         <= 1'b0;
      user_spi_clk <= 1'b0;
      user_spi_ss  <= 1'b1;
      user_spi_din <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state        <= SETUP;
            shreg        <= wdata;
            cnt          <= CNT_SETUP;
            busy         <= 1'b1;
            user_spi_ss  <= 1'b0;
            user_spi_din <= wdata[WORD_BITS-1];
          end
        end
        SETUP: begin
          if (cnt == CNT_ZERO) begin
            state   <= SHIFT;
            cnt     <= CNT_HALF;
            bit_cnt <= BIT_LAST;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        SHIFT: begin
          if (cnt != CNT_ZERO) begin
            cnt <= cnt - CNT_ONE;
          end else if (!user_spi_clk) begin
            user_spi_clk <= 1'b1;
            cnt          <= CNT_HALF;
          end else begin
            // falling edge: next bit goes out, except after the final clock
            user_spi_clk <= 1'b0;
            if (bit_cnt == BIT_ZERO) begin
              state <= HOLD;
              cnt   <= CNT_HOLD;
            end else begin
              bit_cnt      <= bit_cnt - BIT_ONE;
              cnt          <= CNT_HALF;
              shreg        <= {shreg[WORD_BITS-2:0], 1'b0};
              user_spi_din <= shreg[WORD_BITS-2];
            end
          end
        end
        HOLD: begin
          if (cnt == CNT_ZERO) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b1;
            user_spi_ss  <= 1'b1;
            user_spi_din <= 1'b0;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: begin
          state        <= IDLE;
          busy         <= 1'b0;
          user_spi_clk <= 1'b0;
          user_spi_ss  <= 1'b1;
          user_spi_din <= 1'b0;
        end
      endcase
    end
  end

`ifdef ADCDAC_SPI_READBACK_EN
  logic [1:0]           dout_sync;
  logic [WORD_BITS-1:0] capture;
  logic                 sample;
  logic                 finish;

  // The slave moves dout on our falling edge, a full low+high phase before the
  // sample point, so the two-cycle synchronizer lag still lands on the current bit.
  assign sample = (state == SHIFT) && user_spi_clk && (cnt == CNT_ZERO);
  assign finish = (state == HOLD) && (cnt == CNT_ZERO);

  // Two-flop synchronizer for the slave's asynchronous data line
  always_ff @(posedge fpga_clk or posedge rst) begin
    if (rst) begin
      dout_sync <= 2'b00;
    end else begin
      dout_sync <= {dout_sync[0], user_spi_dout};
    end
  end

  // Capture MSB first; rdata is published only as the transaction closes
  always_ff @(posedge fpga_clk or posedge rst) begin
    if (rst) begin
      capture <= {WORD_BITS{1'b0}};
      rdata   <= {WORD_BITS{1'b0}};
    end else begin
      if (sample) begin
        capture <= {capture[WORD_BITS-2:0], dout_sync[1]};
      end
      if (finish) begin
        rdata <= capture;
      end
    end
  end
`else
  logic unused_dout;

  assign unused_dout = user_spi_dout;
  assign rdata       = {WORD_BITS{1'b0}};
`endif

endmodule
